if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces every input of the IF/ID pipeline register: pc/instruction, the hold pair, the hold select and flush.
- Owns the PC and issues one-outstanding requests to the instruction memory.
- Buffers one returned instruction while the hazard unit stalls.
- Inserts bubbles (flush) on redirect or when no instruction is ready.

Parameters:
N, 32, width of PC, address and instruction
RESET_PC, 0, PC loaded on reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: hold IF/ID contents this cycle
redirect_valid  in  1  branch/jump taken
redirect_pc  in  N  new fetch PC
imem_req  out  1  fetch request
imem_addr  out  N  fetch address (= pc_reg)
imem_gnt  in  1  request accepted when imem_req && imem_gnt
imem_rvalid  in  1  response valid, in order, at least 1 cycle after grant
imem_rdata  in  N  fetched instruction
pc_out  out  N  to IF/ID pc_in
instruction_out  out  N  to IF/ID instruction_in
pc_hazard  out  N  to IF/ID pc_hazard (last pair delivered)
instruction_hazard  out  N  to IF/ID instruction_Hazard
ifid_write  out  1  to IF/ID IFIDwrite (1 = reload hold pair)
flush  out  1  to IF/ID flush (1 = bubble, register zeroed)

Behaviour:
- Interface: one clock clk; rst synchronous, active-high.
- On reset:
  - pc_reg=RESET_PC, state=S_IDLE, pend_valid=0, drop=0.
  - last_pc=last_instr=0.
  - Outputs: imem_req=0, flush=1, ifid_write=0, pc_out=instruction_out=0.
- FSM:
  - S_IDLE -> S_REQ after 1 cycle.
  - S_REQ: imem_req=1 only when pend_valid=0. On grant -> S_WAIT.
  - S_WAIT: on rvalid -> S_REQ.
- At most one request outstanding; the pending buffer can therefore never overflow.
- Accepting a response: rvalid, drop=0 and no redirect that cycle. The accepted word is paired with pc_reg, and pc_reg += PC_STEP (mod 2^N).
- Per-cycle IF/ID drive, first match wins:
  1. rst: flush=1.
  2. redirect_valid:
     - flush=1; pc_reg<=redirect_pc; pend_valid<=0; last<=0; state -> S_REQ.
     - If a grant occurs the same cycle, or state is S_WAIT with no rvalid: drop<=1 and state -> S_WAIT.
  3. stall: ifid_write=1, flush=0, hazard outputs = last pair. A response accepted this cycle goes to pend (pend_valid<=1).
  4. pend_valid: deliver pend (flush=0, ifid_write=0, pc_out/instruction_out=pend); pend_valid<=0; last<=pend.
  5. Response accepted: deliver imem_rdata and pc_reg combinationally; last<=that pair.
  6. Otherwise bubble: flush=1; last<=0.
- Dropped response (drop=1 and rvalid): drop<=0, nothing delivered, state -> S_REQ.
- pc_hazard/instruction_hazard always equal last; ifid_write=0 whenever stall=0.
- Reset mid-fetch: in-flight response is ignored only if it arrives while rst=1. The memory is reset alongside this block.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] (delivered instructions) and perf_bubble_cnt[31:0] (cycles with flush=1 and rst=0). Both counters reset to 0 and wrap.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package if_pkg: FSM state enum (S_IDLE, S_REQ, S_WAIT), NOP_INSTR=0, default RESET_PC/PC_STEP constants.
- One natural sub-module, if_skid_buf: one-entry pc+instruction buffer with load/drain/clear.

Test Plan:
- Reset with rst=1 for 2 cycles, then release, memory with 1-cycle grant and 1-cycle rvalid -> first delivery pc_out=0x0, then 0x4, 0x8; flush=1 on every non-delivery cycle.
- stall=1 for 3 cycles while the instruction at 0x8 returns -> ifid_write=1, pc_hazard=0x4 for all 3 cycles. Cycle after stall drops: pc_out=0x8 from pend, no new request while pend_valid.
- redirect_valid with redirect_pc=0x100 while in S_WAIT for 0xC -> flush=1 that cycle; the 0xC response is discarded; next request addr=0x100; delivered pc 0x100 then 0x104.
- Redirect in the same cycle as a grant to 0x10 -> that response is dropped; next imem_addr=redirect_pc.
- stall and redirect_valid in the same cycle -> flush=1, ifid_write=0, pend cleared.
- With IF_PERF_CNT_EN defined: 5 deliveries and 7 bubble cycles -> perf_fetch_cnt=5, perf_bubble_cnt=7.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_N        = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'h0000_0004;
endpackage

// File: rtl/if_skid_buf.sv
// One-entry pc+instruction holding buffer used while the decode stage is stalled.
module if_skid_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  logic [N-1:0] load_pc,
    input  logic [N-1:0] load_instr,
    output logic         valid,
    output logic [N-1:0] pc,
    output logic [N-1:0] instr
);
    logic         valid_reg;
    logic [N-1:0] pc_reg;
    logic [N-1:0] instr_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end

        if (rst) begin
            pc_reg    <= '0;
            instr_reg <= '0;
        end else if (load) begin
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end
    end

    assign valid = valid_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests, drives IF/ID.
// Define IF_PERF_CNT_EN to add delivered-instruction and bubble-cycle counters.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int             N        = DEFAULT_N,
    parameter logic [N-1:0]   RESET_PC = N'(DEFAULT_RESET_PC),
    parameter logic [N-1:0]   PC_STEP  = N'(DEFAULT_PC_STEP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] instruction_out,
    output logic [N-1:0] pc_hazard,
    output logic [N-1:0] instruction_hazard,
    output logic         ifid_write,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_bubble_cnt,
`endif
    output logic         flush
);
    fetch_state_t state_reg, state_next;
    logic [N-1:0] pc_reg, pc_next;
    logic         drop_reg, drop_next;
    logic [N-1:0] last_pc_reg, last_pc_next;
    logic [N-1:0] last_instr_reg, last_instr_next;

    logic         pend_valid, pend_load, pend_drain, pend_clear;
    logic [N-1:0] pend_pc, pend_instr;
    logic         in_wait, rsp, grant, accept;

    if_skid_buf #(.N(N)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (pend_load),
        .drain      (pend_drain),
        .clear      (pend_clear),
        .load_pc    (pc_reg),
        .load_instr (imem_rdata),
        .valid      (pend_valid),
        .pc         (pend_pc),
        .instr      (pend_instr)
    );

    // Requests are suppressed while a word is parked, so the buffer cannot overflow.
    assign imem_req  = !rst && (state_reg == S_REQ) && !pend_valid;
    assign imem_addr = pc_reg;
    assign in_wait   = (state_reg == S_WAIT);
    assign rsp       = imem_rvalid && in_wait;
    assign grant     = imem_req && imem_gnt;
    assign accept    = rsp && !drop_reg && !redirect_valid;

    assign pc_hazard          = last_pc_reg;
    assign instruction_hazard = last_instr_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drop_next       = drop_reg;
        last_pc_next    = last_pc_reg;
        last_instr_next = last_instr_reg;
        pend_load       = 1'b0;
        pend_drain      = 1'b0;
        pend_clear      = 1'b0;
        flush           = 1'b1;
        ifid_write      = 1'b0;
        pc_out          = '0;
        instruction_out = N'(NOP_INSTR);

        if (!rst) begin
            case (state_reg)
                S_IDLE:  state_next = S_REQ;
                S_REQ:   if (grant) state_next = S_WAIT;
                S_WAIT:  if (rsp) state_next = S_REQ;
                default: state_next = S_IDLE;
            endcase
            if (rsp && drop_reg) begin
                drop_next = 1'b0;
            end
            if (accept) begin
                pc_next = pc_reg + PC_STEP;
            end

            if (redirect_valid) begin
                pc_next         = redirect_pc;
                pend_clear      = 1'b1;
                last_pc_next    = '0;
                last_instr_next = '0;
                // A request already in flight must have its response discarded.
                if (grant || (in_wait && !rsp)) begin
                    drop_next  = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    drop_next  = 1'b0;
                    state_next = S_REQ;
                end
            end else if (stall) begin
                flush      = 1'b0;
                ifid_write = 1'b1;
                pend_load  = accept;
            end else if (pend_valid) begin
                flush           = 1'b0;
                pc_out          = pend_pc;
                instruction_out = pend_instr;
                pend_drain      = 1'b1;
                last_pc_next    = pend_pc;
                last_instr_next = pend_instr;
            end else if (accept) begin
                flush           = 1'b0;
                pc_out          = pc_reg;
                instruction_out = imem_rdata;
                last_pc_next    = pc_reg;
                last_instr_next = imem_rdata;
            end else begin
                last_pc_next    = '0;
                last_instr_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            drop_reg       <= 1'b0;
            last_pc_reg    <= '0;
            last_instr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drop_reg       <= drop_next;
            last_pc_reg    <= last_pc_next;
            last_instr_reg <= last_instr_next;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg, bubble_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (!flush && !ifid_write) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            if (flush) bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_reg;
    assign perf_bubble_cnt = bubble_cnt_reg;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level model checked every cycle plus directed literal checks.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_out, instruction_out, pc_hazard, instruction_hazard;
    logic        ifid_write, flush;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    logic [31:0] delivered [$];

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_gnt           (imem_gnt),
        .imem_rvalid        (imem_rvalid),
        .imem_rdata         (imem_rdata),
        .pc_out             (pc_out),
        .instruction_out    (instruction_out),
        .pc_hazard          (pc_hazard),
        .instruction_hazard (instruction_hazard),
        .ifid_write         (ifid_write),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt     (perf_fetch_cnt),
        .perf_bubble_cnt    (perf_bubble_cnt),
`endif
        .flush              (flush)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: grant as driven, response `lat` cycles after grant, reset together with the DUT.
    initial begin : mem
        logic g, r;
        logic [31:0] a, saved;
        logic busy;
        int cnt;
        busy = 1'b0; cnt = 0; saved = '0;
        forever begin
            @(negedge clk);
            g = imem_req && imem_gnt;
            a = imem_addr;
            r = rst;
            @(posedge clk);
            #2;
            imem_rvalid = 1'b0;
            if (r) begin
                busy = 1'b0;
            end else begin
                if (g) begin
                    busy = 1'b1; cnt = lat; saved = a;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = instr_of(saved);
                        busy        = 1'b0;
                    end
                end
            end
        end
    end

    // Behavioural model: tracks PC, whether a request is outstanding, the parked word and the
    // last delivered pair; checks DUT outputs each cycle, then advances to the next cycle.
    initial begin : model
        logic [31:0] m_pc, m_pend_pc, m_pend_in, m_last_pc, m_last_in;
        logic m_ok, m_idle, m_busy, m_pend_v, m_drop;
        logic e_req, rv, acc, d_pend, d_new, e_flush, e_wr, grant;
        int m_fetch, m_bubble;
        m_ok = 1'b0; m_idle = 1'b1; m_busy = 1'b0; m_pend_v = 1'b0; m_drop = 1'b0;
        m_pc = '0; m_pend_pc = '0; m_pend_in = '0; m_last_pc = '0; m_last_in = '0;
        m_fetch = 0; m_bubble = 0;
        forever begin
            @(negedge clk);
            e_req   = !rst && !m_idle && !m_busy && !m_pend_v;
            rv      = imem_rvalid;
            acc     = !rst && rv && !m_drop && !redirect_valid;
            d_pend  = !rst && !redirect_valid && !stall && m_pend_v;
            d_new   = !rst && !redirect_valid && !stall && !m_pend_v && acc;
            e_flush = rst || redirect_valid || (!stall && !d_pend && !d_new);
            e_wr    = !rst && !redirect_valid && stall;
            grant   = e_req && imem_gnt;

            if (m_ok) begin
                check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
                if (e_req) check("imem_addr", imem_addr, m_pc);
                check("flush", {31'd0, flush}, {31'd0, e_flush});
                check("ifid_write", {31'd0, ifid_write}, {31'd0, e_wr});
                check("pc_hazard", pc_hazard, m_last_pc);
                check("instruction_hazard", instruction_hazard, m_last_in);
                if (d_pend) begin
                    check("pc_out_pend", pc_out, m_pend_pc);
                    check("instr_out_pend", instruction_out, m_pend_in);
                end
                if (d_new) begin
                    check("pc_out", pc_out, m_pc);
                    check("instr_out", instruction_out, instr_of(m_pc));
                end
                if (rst) begin
                    check("pc_out_rst", pc_out, 32'd0);
                    check("instr_out_rst", instruction_out, 32'd0);
                end
`ifdef IF_PERF_CNT_EN
                check("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
                check("perf_bubble_cnt", perf_bubble_cnt, 32'(m_bubble));
`endif
            end

            if (!rst && !flush && !ifid_write) begin
                delivered.push_back(pc_out);
                $display("deliver pc=0x%08h instr=0x%08h t=%0t", pc_out, instruction_out, $time);
            end

            if (rst) begin
                m_ok = 1'b1; m_idle = 1'b1; m_busy = 1'b0; m_pend_v = 1'b0; m_drop = 1'b0;
                m_pc = '0; m_last_pc = '0; m_last_in = '0; m_fetch = 0; m_bubble = 0;
            end else begin
                m_idle = 1'b0;
                if (d_pend || d_new) m_fetch++;
                if (e_flush) m_bubble++;
                if (redirect_valid) begin
                    m_busy    = grant || (m_busy && !rv);
                    m_drop    = m_busy;
                    m_pc      = redirect_pc;
                    m_pend_v  = 1'b0;
                    m_last_pc = '0;
                    m_last_in = '0;
                end else begin
                    if (stall) begin
                        if (acc) begin
                            m_pend_v = 1'b1; m_pend_pc = m_pc; m_pend_in = instr_of(m_pc);
                        end
                    end else if (d_pend) begin
                        m_last_pc = m_pend_pc; m_last_in = m_pend_in; m_pend_v = 1'b0;
                    end else if (d_new) begin
                        m_last_pc = m_pc; m_last_in = instr_of(m_pc);
                    end else begin
                        m_last_pc = '0; m_last_in = '0;
                    end
                    if (rv) begin
                        m_busy = 1'b0; m_drop = 1'b0;
                    end
                    if (grant) m_busy = 1'b1;
                    if (acc) m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                        input logic g);
        @(posedge clk);
        #1;
        rst = r; stall = s; redirect_valid = rd; redirect_pc = rp; imem_gnt = g;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [31:0] exp_list [13];
        exp_list = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h200, 32'h204,
                     32'h300, 32'h304, 32'h308, 32'h30C, 32'h0, 32'h4};

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("rst_flush", {31'd0, flush}, 32'd1);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_ifid_write", {31'd0, ifid_write}, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_pc_hazard", pc_hazard, 32'd0);

        step(0, 0, 0, 0, 1);                             // R0 idle
        step(0, 0, 0, 0, 1);                             // R1 request 0x0
        step(0, 0, 0, 0, 1);                             // R2 deliver 0x0
        check("first_pc", pc_out, 32'h0);
        check("first_instr", instruction_out, 32'hC0DE_0000);
        check("first_flush", {31'd0, flush}, 32'd0);
        step(0, 0, 0, 0, 1);                             // R3
        step(0, 0, 0, 0, 1);                             // R4 deliver 0x4
        for (int i = 0; i < 3; i++) begin                // R5..R7 stall while 0x8 returns
            step(0, 1, 0, 0, 1);
            check("stall_ifid_write", {31'd0, ifid_write}, 32'd1);
            check("stall_pc_hazard", pc_hazard, 32'h4);
        end
        step(0, 0, 0, 0, 1);                             // R8 deliver parked 0x8
        check("pend_pc_out", pc_out, 32'h8);
        check("pend_no_req", {31'd0, imem_req}, 32'd0);
        lat = 3;
        step(0, 0, 0, 0, 1);                             // R9 request 0xC
        step(0, 0, 1, 32'h100, 1);                       // R10 redirect while waiting
        check("redir_flush", {31'd0, flush}, 32'd1);
        lat = 1;
        step(0, 0, 0, 0, 1);                             // R11
        step(0, 0, 0, 0, 1);                             // R12 stale 0xC dropped
        step(0, 0, 0, 0, 1);                             // R13
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 1);                             // R14 deliver 0x100
        check("redir_pc_out", pc_out, 32'h100);
        step(0, 0, 0, 0, 1);                             // R15
        step(0, 0, 0, 0, 1);                             // R16 deliver 0x104
        step(0, 0, 1, 32'h200, 1);                       // R17 redirect with grant to 0x108
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_lit", perf_fetch_cnt, 32'd5);
        check("perf_bubble_lit", perf_bubble_cnt, 32'd9);
`endif
        step(0, 0, 0, 0, 1);                             // R18 dropped response
        step(0, 0, 0, 0, 1);                             // R19
        check("grant_redir_addr", imem_addr, 32'h200);
        step(0, 0, 0, 0, 1);                             // R20
        step(0, 0, 0, 0, 1);                             // R21
        step(0, 0, 0, 0, 1);                             // R22
        step(0, 1, 0, 0, 1);                             // R23
        step(0, 1, 0, 0, 1);                             // R24 0x208 parked
        step(0, 1, 1, 32'h300, 1);                       // R25 stall + redirect
        check("stall_redir_flush", {31'd0, flush}, 32'd1);
        check("stall_redir_ifid", {31'd0, ifid_write}, 32'd0);
        step(0, 0, 0, 0, 1);                             // R26 parked word gone
        check("pend_cleared_flush", {31'd0, flush}, 32'd1);
        check("pend_cleared_addr", imem_addr, 32'h300);
        step(0, 0, 0, 0, 1);                             // R27
        step(0, 0, 0, 0, 0);                             // R28 grant withheld
        step(0, 0, 0, 0, 0);                             // R29
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1); // R30..R35
        step(1, 0, 0, 0, 1);                             // R36 reset
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1); // R37..R41

        check("delivered_count", 32'(delivered.size()), 32'd13);
        for (int i = 0; i < 13; i++) begin
            if (i < delivered.size()) check("delivered_pc", delivered[i], exp_list[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
